parity_serial_rx: RTL
=====================

Name: parity_serial_rx

Overview:
- Receiving end of the team's 8-bit parity link. The transmit side computes the parity bit as XOR-reduce of the 8 data bits for even parity, and as its complement for odd parity.
- This block deserialises frames from a single serial line: 1 start, 8 data LSB-first, 1 parity, 1 stop.
- It checks parity and framing, presents the byte with a one-cycle valid strobe, and drives sticky status on the board RGB LED.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; must be even and ≥4.
- ODD_PARITY, default 0: 0 = even parity (data^parity must XOR to 0); 1 = odd (must XOR to 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- clr  in  1  synchronous clear of sticky RGB0 status.
- data  out  8  last received byte.
- data_valid  out  1  one-cycle strobe: new frame completed.
- parity_err  out  1  parity mismatch on last frame; qualifies data.
- frame_err  out  1  stop bit sampled 0 on last frame.
- busy  out  1  high while a frame is being received (state ≠ IDLE).
- RGB0  out  3  sticky status: [0] good frame seen, [1] parity error seen, [2] framing error seen.

Behaviour:
- Reset (rst_n low, async): rx synchroniser flops = 1, state = IDLE, counters = 0, data = 0x00, data_valid/parity_err/frame_err/busy = 0, RGB0 = 3'b000.
- rx passes through a 2-flop synchroniser, rxs = second flop. All decisions use rxs only.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rxs==0 → START, clear bit-clock counter.
  - START: at count CLKS_PER_BIT/2−1, sample rxs.
    - If 1 (glitch), → IDLE; no output.
    - Else restart counter → DATA.
  - DATA: every CLKS_PER_BIT cycles sample rxs into bit position bit_idx (LSB first). After bit 7 → PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit → IDLE. On this edge register the outputs:
    - data ← shift register.
    - parity_err ← (^data_bits ^ pbit) != ODD_PARITY.
    - frame_err ← ~stop.
    - data_valid ← 1 for exactly one cycle.
- Sampling points: all samples are at bit centres, i.e. cycle CLKS_PER_BIT/2 + k·CLKS_PER_BIT after the first low rxs, k = 0..10.
- Latency: data_valid is high in the cycle after the stop-bit sample edge. rx-to-rxs adds 2 cycles.
- data is updated and data_valid fires even when either error flag is set. Consumers must qualify data with the error flags.
- parity_err, frame_err and data hold until the next data_valid.
- Back-to-back frames: IDLE is re-entered right after the stop sample. A start bit immediately following is accepted, as long as its falling edge comes after the stop-bit centre.
- A low stop bit (break) gives frame_err=1. The FSM returns to IDLE and re-triggers START only if rxs is still low. A held-low line therefore produces repeated framing-error frames.
- RGB0 update on data_valid:
  - bit0 |= ~parity_err & ~frame_err.
  - bit1 |= parity_err.
  - bit2 |= frame_err.
- clr: RGB0 ← 0. If clr and data_valid occur in the same cycle, clr wins.
- Reset mid-frame: the frame is abandoned, outputs return to reset values and no data_valid is produced. After release, reception resumes at the next falling edge seen in IDLE.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Even parity, CLKS_PER_BIT=16: send 0xA5, parity 0, stop 1 → one data_valid, data=0xA5, parity_err=0, frame_err=0, RGB0=3'b001.
- Send 0x01 with parity 0 → data=0x01, parity_err=1, frame_err=0, RGB0[1]=1. Then pulse clr → RGB0=3'b000.
- Send 0x3C, parity 0, stop 0 → data_valid, data=0x3C, frame_err=1, RGB0=3'b100.
- rx low for 4 cycles then high → no data_valid, busy returns to 0 within CLKS_PER_BIT/2+3 cycles, data unchanged.
- ODD_PARITY=1: 0x07 with parity 0 → parity_err=0. Same byte with parity 1 → parity_err=1.
- Two frames back-to-back (0xFF then 0x00, zero idle gap) → two data_valid strobes 11·CLKS_PER_BIT apart, correct bytes. Then assert rst_n=0 during bit 4 of a third frame → all outputs 0, no strobe.

Source files
------------

// File: rtl/parity_serial_rx.sv
// parity_serial_rx: receiver for the 8-bit parity link.
// Frame format: 1 start, 8 data (LSB first), 1 parity, 1 stop.
// The receiver samples at bit centres, checks parity and framing, emits the
// byte with a one-cycle valid strobe and keeps sticky status on RGB0.
module parity_serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD_PARITY   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clr,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] RGB0
);

    // Counter wide enough to reach CLKS_PER_BIT-1.
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Terminal counts: half a bit to reach the start-bit centre, then a
    // full bit between successive centres.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    // Expected XOR of data bits and parity bit for a clean frame.
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            pbit, pbit_n;
    logic [7:0]      data_n;
    logic            parity_err_n;
    logic            frame_err_n;
    logic            data_valid_n;

    // Two-flop synchroniser; rxs is the only view of the line used below.
    logic rx_s1;
    logic rxs;

    // Synchronise the asynchronous serial line; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
        end
    end

    // Register FSM state, bit timing and the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            pbit       <= 1'b0;
            data       <= 8'h00;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            pbit       <= pbit_n;
            data       <= data_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
            data_valid <= data_valid_n;
            busy       <= (state_n != IDLE);
        end
    end

    // Next-state and datapath: each state waits for its bit centre, samples
    // rxs once, then rearms the counter for the next bit.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt + 1'b1;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        pbit_n       = pbit;
        data_n       = data;
        parity_err_n = parity_err;
        frame_err_n  = frame_err;
        data_valid_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (!rxs) begin
                    state_n = START;
                end
            end

            START: begin
                // A high line at the start-bit centre was only a glitch.
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = PARITY;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end

            PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    pbit_n  = rxs;
                    state_n = STOP;
                end
            end

            STOP: begin
                // Results are published even on errors; the flags qualify data.
                if (cnt == FULL_M1) begin
                    cnt_n        = '0;
                    state_n      = IDLE;
                    data_n       = shreg;
                    parity_err_n = ((^shreg) ^ pbit) != ODD_BIT;
                    frame_err_n  = ~rxs;
                    data_valid_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Sticky status LED; a clear in the same cycle as a strobe wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RGB0 <= 3'b000;
        end else if (clr) begin
            RGB0 <= 3'b000;
        end else if (data_valid) begin
            RGB0[0] <= RGB0[0] | (~parity_err & ~frame_err);
            RGB0[1] <= RGB0[1] | parity_err;
            RGB0[2] <= RGB0[2] | frame_err;
        end
    end

endmodule
